// File: rtl/program_loader.sv
// program_loader: parses a framed program image from a serial byte stream
// and writes big-endian 16-bit words into consecutive instruction-cache cells.
//
// Frame: HEADER, CNT_HI, CNT_LO, 2N payload bytes, CHK (XOR of payload).
//
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   rx_valid, rx_data  one-cycle byte strobe and byte from the serial receiver
//   download_program   single-cycle cache write strobe per word
//   instruction_index  cache write address
//   instruction        cache write data
//   loading            high while a frame is in progress (holds the core in reset)
//   done, error        sticky completion / failure flags
//
// Optional: define LOADER_TIMEOUT_EN to build an inter-byte timeout that
// aborts a stalled frame after TIMEOUT_CYCLES idle cycles.
module program_loader #(
  parameter int unsigned DEPTH          = 1000,
  parameter int unsigned ADDR_W         = 10,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              download_program,
  output logic [ADDR_W-1:0] instruction_index,
  output logic [15:0]       instruction,
  output logic              loading,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [15:0]       instr_q, instr_d;
  logic [7:0]        chk_q, chk_d;
  logic              strobe_q, strobe_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [15:0]       n_full;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  // Timeout length only matters when the counter is built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wcnt_d    = wcnt_q;
    index_d   = index_q;
    instr_d   = instr_q;
    chk_d     = chk_q;
    strobe_d  = 1'b0;
    loading_d = loading_q;
    done_d    = done_q;
    error_d   = error_q;
    n_full    = {n_q[15:8], rx_data};

    // Address advances the cycle after each strobe; it stops at the last cell.
    if (strobe_q && (index_q != ADDR_W'(DEPTH - 1))) begin
      index_d = index_q + ADDR_W'(1);
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_data == HEADER) begin
            state_d   = S_CNT_HI;
            loading_d = 1'b1;
            done_d    = 1'b0;
            error_d   = 1'b0;
            chk_d     = '0;
            wcnt_d    = '0;
            index_d   = '0;
          end
        end
        S_CNT_HI: begin
          n_d     = {rx_data, 8'h00};
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          n_d = n_full;
          if ({16'h0000, n_full} > DEPTH) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            loading_d = 1'b0;
          end else if (n_full == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          instr_d[15:8] = rx_data;
          chk_d         = chk_q ^ rx_data;
          state_d       = S_DATA_LO;
        end
        S_DATA_LO: begin
          instr_d[7:0] = rx_data;
          chk_d        = chk_q ^ rx_data;
          strobe_d     = 1'b1;
          wcnt_d       = wcnt_q + 16'd1;
          state_d      = ((wcnt_q + 16'd1) == n_q) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          loading_d = 1'b0;
          if (rx_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef LOADER_TIMEOUT_EN
    tmo_d = '0;
    if (state_q inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK}) begin
      if (!rx_valid) begin
        // Expiry only in a byte-free cycle, so a partial word is never strobed.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_ERROR;
          error_d   = 1'b1;
          loading_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      wcnt_q    <= '0;
      index_q   <= '0;
      instr_q   <= '0;
      chk_q     <= '0;
      strobe_q  <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      wcnt_q    <= wcnt_d;
      index_q   <= index_d;
      instr_q   <= instr_d;
      chk_q     <= chk_d;
      strobe_q  <= strobe_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign download_program  = strobe_q;
  assign instruction_index = index_q;
  assign instruction       = instr_q;
  assign loading           = loading_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives framed byte streams into program_loader and
// compares strobes, write data and status flags against a stream-level model.
module tb_program_loader;

  localparam int unsigned DEPTH  = 1000;
  localparam int unsigned ADDR_W = 10;
  localparam logic [7:0]  HDR    = 8'hA5;
`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1000000;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [15:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              download_program;
  logic [ADDR_W-1:0] instruction_index;
  logic [15:0]       instruction;
  logic              loading;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  wr_t exp_wr[$];
  wr_t got_wr[$];
  bit  exp_strobe[$];
  bit  m_done, m_error, m_loading;
  int  timing_bad, wr_bad, first_bad;

  program_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADER(HDR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .download_program(download_program), .instruction_index(instruction_index),
    .instruction(instruction), .loading(loading), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (download_program === 1'b1) got_wr.push_back(wr_t'({instruction_index, instruction}));
  end

  // Stream-level reference: walks the bytes as frames, producing the list of
  // expected cache writes, which byte completes a word, and the final flags.
  function automatic void model(input bq_t s);
    int  k = 0;
    int  n;
    bit  partial;
    logic [7:0] x;
    wr_t e;
    exp_wr.delete();
    exp_strobe.delete();
    foreach (s[i]) exp_strobe.push_back(1'b0);
    while (k < s.size()) begin
      if (s[k] != HDR) begin k++; continue; end
      k++;
      m_done = 0; m_error = 0; m_loading = 1;
      if (k + 2 > s.size()) break;
      n = int'({s[k], s[k+1]});
      k += 2;
      if (n > int'(DEPTH)) begin m_error = 1; m_loading = 0; continue; end
      x = 8'h00;
      partial = 0;
      for (int w = 0; w < n; w++) begin
        if (k + 2 > s.size()) begin partial = 1; break; end
        e.idx  = w[ADDR_W-1:0];
        e.data = {s[k], s[k+1]};
        exp_wr.push_back(e);
        x = x ^ s[k] ^ s[k+1];
        exp_strobe[k+1] = 1'b1;
        k += 2;
      end
      if (partial || k >= s.size()) break;
      if (s[k] == x) m_done = 1; else m_error = 1;
      m_loading = 0;
      k++;
    end
  endfunction

  // Drives a stream with random idle gaps; tallies strobe-timing and
  // write-list differences for the calling scenario to judge.
  task automatic send_stream(input bq_t s, input int unsigned max_gap);
    bit pend = 0;
    int unsigned g;
    int m;
    model(s);
    got_wr.delete();
    timing_bad = 0;
    for (int k = 0; k < s.size(); k++) begin
      g = $urandom_range(max_gap, 0);
      for (int unsigned j = 0; j < g; j++) begin
        @(negedge clk);
        if (download_program !== pend) timing_bad++;
        pend = 0; rx_valid = 1'b0;
      end
      @(negedge clk);
      if (download_program !== pend) timing_bad++;
      rx_valid = 1'b1; rx_data = s[k]; pend = exp_strobe[k];
    end
    repeat (3) begin
      @(negedge clk);
      if (download_program !== pend) timing_bad++;
      pend = 0; rx_valid = 1'b0;
    end
    wr_bad = 0; first_bad = -1;
    m = (got_wr.size() > exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) begin
      if (i >= got_wr.size() || i >= exp_wr.size() || got_wr[i] !== exp_wr[i]) begin
        if (wr_bad == 0) first_bad = i;
        wr_bad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_done = 0; m_error = 0; m_loading = 0;
    @(negedge clk);
    checks++; if (download_program !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b want=0", download_program); end
    checks++; if (instruction_index !== '0) begin errors++; $display("FAIL reset_index got=%0d want=0", instruction_index); end
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h want=0000", instruction); end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got=%b want=0", loading); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", error); end
  endtask

  task automatic test_basic();
    bq_t s = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    send_stream(s, 2);
    checks++; if (timing_bad !== 0) begin errors++; $display("FAIL basic_timing bad_cycles=%0d want=0", timing_bad); end
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL basic_writes bad=%0d at %0d got_n=%0d want_n=%0d", wr_bad, first_bad, got_wr.size(), exp_wr.size()); end
    checks++; if (got_wr.size() !== 2 || got_wr[0] !== wr_t'({10'd0, 16'h0123}) || got_wr[1] !== wr_t'({10'd1, 16'h4567}))
      begin errors++; $display("FAIL basic_words got_n=%0d want two words 0:0123 1:4567", got_wr.size()); end
    checks++; if ({done, error, loading} !== 3'b100) begin errors++; $display("FAIL basic_flags got=%b want=100", {done, error, loading}); end
  endtask

  task automatic test_bad_checksum();
    bq_t s  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h45};
    bq_t s2 = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_stream(s, 1);
    checks++; if (got_wr.size() !== 2 || wr_bad !== 0) begin errors++; $display("FAIL badchk_writes got_n=%0d bad=%0d want_n=2", got_wr.size(), wr_bad); end
    checks++; if ({done, error, loading} !== 3'b010) begin errors++; $display("FAIL badchk_flags got=%b want=010", {done, error, loading}); end
    send_stream(s2, 1);
    checks++; if (got_wr.size() !== 0 || timing_bad !== 0) begin errors++; $display("FAIL empty_writes got_n=%0d timing_bad=%0d want 0", got_wr.size(), timing_bad); end
    checks++; if ({done, error, loading} !== 3'b100) begin errors++; $display("FAIL empty_flags got=%b want=100", {done, error, loading}); end
  endtask

  task automatic test_length();
    bq_t s = '{8'hA5, 8'h03, 8'hE9};
    logic [7:0] b, x;
    send_stream(s, 1);
    checks++; if (got_wr.size() !== 0) begin errors++; $display("FAIL over_writes got_n=%0d want=0", got_wr.size()); end
    checks++; if ({done, error, loading} !== 3'b010) begin errors++; $display("FAIL over_flags got=%b want=010", {done, error, loading}); end
    s = '{8'hA5, 8'h03, 8'hE8};
    x = 8'h00;
    for (int i = 0; i < 2000; i++) begin b = 8'($urandom); x ^= b; s.push_back(b); end
    s.push_back(x);
    send_stream(s, 0);
    checks++; if (wr_bad !== 0 || timing_bad !== 0) begin errors++; $display("FAIL full_writes bad=%0d at %0d timing_bad=%0d", wr_bad, first_bad, timing_bad); end
    checks++; if (got_wr.size() !== 1000 || got_wr[got_wr.size()-1].idx !== 10'd999)
      begin errors++; $display("FAIL full_last got_n=%0d want_n=1000 last_idx=999", got_wr.size()); end
    checks++; if ({done, error, loading} !== 3'b100) begin errors++; $display("FAIL full_flags got=%b want=100", {done, error, loading}); end
  endtask

  task automatic test_back_to_back();
    bq_t s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    send_stream(s, 0);
    checks++; if (timing_bad !== 0) begin errors++; $display("FAIL b2b_timing bad_cycles=%0d want=0", timing_bad); end
    checks++; if (got_wr.size() !== 1 || got_wr[0] !== wr_t'({10'd0, 16'h1234}))
      begin errors++; $display("FAIL b2b_word got_n=%0d want one word 0:1234", got_wr.size()); end
    checks++; if ({done, error, loading} !== 3'b100) begin errors++; $display("FAIL b2b_flags got=%b want=100", {done, error, loading}); end
  endtask

  task automatic test_reset_mid_frame();
    bq_t s  = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    bq_t s2 = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
    send_stream(s, 1);
    checks++; if (wr_bad !== 0 || loading !== 1'b1) begin errors++; $display("FAIL partial_state bad=%0d loading=%b want 0/1", wr_bad, loading); end
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    m_done = 0; m_error = 0; m_loading = 0;
    got_wr.delete();
    repeat (3) @(negedge clk);
    checks++; if ({loading, done, error} !== 3'b000 || got_wr.size() !== 0)
      begin errors++; $display("FAIL midreset got flags=%b strobes=%0d want 000/0", {loading, done, error}, got_wr.size()); end
    send_stream(s2, 1);
    checks++; if (got_wr.size() !== 1 || got_wr[0] !== wr_t'({10'd0, 16'hABCD}))
      begin errors++; $display("FAIL midreset_reload got_n=%0d want one word 0:abcd", got_wr.size()); end
    checks++; if ({done, error, loading} !== 3'b100) begin errors++; $display("FAIL midreset_flags got=%b want=100", {done, error, loading}); end
  endtask

  task automatic test_random();
    bq_t s;
    logic [7:0] b, x;
    int unsigned n;
    for (int f = 0; f < 12; f++) begin
      s.delete();
      repeat ($urandom_range(3, 0)) begin b = 8'($urandom); if (b == HDR) b = 8'h00; s.push_back(b); end
      // Two frames per stream so a header can follow DONE/ERROR immediately.
      for (int r = 0; r < 2; r++) begin
        n = ($urandom_range(7, 0) == 0) ? $urandom_range(65535, DEPTH + 1) : $urandom_range(12, 0);
        s.push_back(HDR); s.push_back(8'(n >> 8)); s.push_back(8'(n));
        if (n <= DEPTH) begin
          x = 8'h00;
          for (int unsigned i = 0; i < 2 * n; i++) begin b = 8'($urandom); x ^= b; s.push_back(b); end
          if ($urandom_range(1, 0) == 1) x ^= 8'($urandom_range(255, 1));
          s.push_back(x);
        end
      end
      send_stream(s, 2);
      checks++; if (timing_bad !== 0) begin errors++; $display("FAIL rand%0d_timing bad_cycles=%0d want=0", f, timing_bad); end
      checks++; if (wr_bad !== 0) begin errors++; $display("FAIL rand%0d_writes bad=%0d at %0d got_n=%0d want_n=%0d", f, wr_bad, first_bad, got_wr.size(), exp_wr.size()); end
      checks++; if ({done, error, loading} !== {m_done, m_error, m_loading})
        begin errors++; $display("FAIL rand%0d_flags got=%b want=%b", f, {done, error, loading}, {m_done, m_error, m_loading}); end
    end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bq_t s = '{8'hA5, 8'h00, 8'h01, 8'h12};
    int strobes = 0;
    for (int k = 0; k < s.size(); k++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = s[k];
    end
    got_wr.delete();
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (download_program === 1'b1) strobes++;
      if (j == 16) begin
        checks++; if (error !== 1'b0 || loading !== 1'b1) begin errors++; $display("FAIL tmo_early error=%b loading=%b want 0/1", error, loading); end
      end
      if (j == 17) begin
        checks++; if (error !== 1'b1 || loading !== 1'b0) begin errors++; $display("FAIL tmo_fire error=%b loading=%b want 1/0", error, loading); end
      end
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL tmo_strobes got=%0d want=0", strobes); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_length();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
